instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 180 ++++++++++++++++++
 tb/tb_instr_encoder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// ============================================================================
// Module      : instr_encoder
// Description : Packs instruction fields into 32-bit words and streams them
//               into instruction memory, one session per start pulse, until
//               an EXIT word is written. Optional field legality checking is
//               enabled by defining INSTR_ENC_CHECK_EN.
//               Opcodes: Rtype=000, Itype=001, Mtype=010, Ctype=011; the Ctype
//               funct3 is in_funct4[2:0] (111=EXIT, 110=SYNC).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_op,
    input  logic                  in_pred,
    input  logic [3:0]            in_funct4,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [13:0]           in_imm,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    input  logic                  imem_ready,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] count,
    output logic                  err
);

    localparam logic [2:0] c_OP_RTYPE = 3'b000;
    localparam logic [2:0] c_OP_MTYPE = 3'b010;
    localparam logic [2:0] c_OP_CTYPE = 3'b011;
    localparam logic [ADDR_WIDTH-1:0] c_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_EMIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                  r_state;
    logic                    r_in_ready;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_done;
    logic [ADDR_WIDTH-1:0]   r_count;
    logic                    r_exit;

    logic [31:0]             w_word;
    logic [DATA_WIDTH-1:0]   w_word_ext;
    logic                    w_ctl_short;
    logic                    w_is_exit;

    // EXIT and SYNC carry no operands: only op, pred and funct4 survive.
    assign w_ctl_short = (in_op == c_OP_CTYPE) && (in_funct4[2:1] == 2'b11);
    assign w_is_exit   = (in_op == c_OP_CTYPE) && (in_funct4[2:0] == 3'b111);

    always_comb begin
        w_word        = '0;
        w_word[31:29] = in_op;
        w_word[28]    = in_pred;
        w_word[13:10] = in_funct4;
        if (in_op == c_OP_RTYPE) begin
            w_word[27:23] = in_rd;
            w_word[22:18] = in_rs1;
            w_word[9:5]   = in_rs2;
        end else if (!w_ctl_short) begin
            w_word[27:23] = in_rd;
            w_word[22:18] = in_rs1;
            w_word[17:14] = in_imm[13:10];
            w_word[9:0]   = in_imm[9:0];
        end
    end

    generate
        if (DATA_WIDTH > 32) begin : g_wide
            assign w_word_ext = {{(DATA_WIDTH-32){1'b0}}, w_word};
        end else begin : g_exact
            assign w_word_ext = w_word[DATA_WIDTH-1:0];
        end
    endgenerate

`ifdef INSTR_ENC_CHECK_EN
    logic r_err;
    logic w_illegal;

    assign w_illegal = (in_op > c_OP_CTYPE)
                    || ((in_op == c_OP_MTYPE) && (in_funct4 > 4'd1))
                    || ((in_op == c_OP_CTYPE) && (in_funct4[2:1] == 2'b10));
    assign err = r_err;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            r_err <= 1'b0;
        end else if (r_state == S_ACCEPT && in_valid && w_illegal) begin
            r_err <= 1'b1;
        end
    end
`else
    logic w_illegal;

    assign w_illegal = 1'b0;
    assign err       = 1'b0;
`endif

    // start has priority over every state, including a pending EMIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_done     <= 1'b0;
            r_count    <= '0;
            r_exit     <= 1'b0;
        end else if (start) begin
            r_state    <= S_ACCEPT;
            r_in_ready <= 1'b1;
            r_we       <= 1'b0;
            r_addr     <= base_addr;
            r_done     <= 1'b0;
            r_count    <= '0;
        end else begin
            case (r_state)
                S_ACCEPT: begin
                    if (in_valid && !w_illegal) begin
                        r_wdata    <= w_word_ext;
                        r_exit     <= w_is_exit;
                        r_we       <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_state    <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (imem_ready) begin
                        r_we   <= 1'b0;
                        r_addr <= r_addr + c_ONE;
                        if (r_count != {ADDR_WIDTH{1'b1}}) begin
                            r_count <= r_count + c_ONE;
                        end
                        if (r_exit) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_ACCEPT;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                S_IDLE, S_DONE: begin
                    r_in_ready <= 1'b0;
                    r_we       <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign done       = r_done;
    assign count      = r_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// Module      : tb_instr_encoder
// Description : Self-checking bench for instr_encoder; directed scenarios plus
//               randomized fields checked against an arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_op = '0;
    logic          in_pred = 1'b0;
    logic [3:0]    in_funct4 = '0;
    logic [4:0]    in_rd = '0;
    logic [4:0]    in_rs1 = '0;
    logic [4:0]    in_rs2 = '0;
    logic [13:0]   in_imm = '0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic          imem_ready = 1'b0;
    logic          done;
    logic [AW-1:0] count;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;

    logic [AW-1:0] m_addr = '0;
    logic [AW-1:0] m_count = '0;

    instr_encoder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_pred(in_pred), .in_funct4(in_funct4), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .imem_ready(imem_ready), .done(done), .count(count), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (imem_we && imem_ready) wr_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected word built from field weights rather than bit slicing.
    function automatic logic [31:0] ref_word(input int op, pred, f4, rd, rs1, rs2, imm);
        longint w;
        w = longint'(op) * 536870912 + longint'(pred) * 268435456 + longint'(f4) * 1024;
        if (op == 0)
            w += longint'(rd) * 8388608 + longint'(rs1) * 262144 + longint'(rs2) * 32;
        else if (!(op == 3 && (f4 % 8) >= 6))
            w += longint'(rd) * 8388608 + longint'(rs1) * 262144
               + longint'(imm / 1024) * 16384 + longint'(imm % 1024);
        return w[31:0];
    endfunction

    function automatic bit ref_legal(input int op, f4);
`ifdef INSTR_ENC_CHECK_EN
        if (op > 3) return 1'b0;
        if (op == 2 && f4 > 1) return 1'b0;
        if (op == 3 && ((f4 % 8) == 4 || (f4 % 8) == 5)) return 1'b0;
`endif
        return 1'b1;
    endfunction

    task automatic do_start(input logic [AW-1:0] b);
        start = 1'b1;
        base_addr = b;
        tick();
        start = 1'b0;
        m_addr = b;
        m_count = '0;
    endtask

    task automatic send(input int op, pred, f4, rd, rs1, rs2, imm, dly, input string tag);
        logic [31:0] exp;
        int w0;
        bit legal, is_exit;
        exp = ref_word(op, pred, f4, rd, rs1, rs2, imm);
        legal = ref_legal(op, f4);
        is_exit = (op == 3) && ((f4 % 8) == 7);
        w0 = wr_cnt;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL %s ready_pre: got %b expected 1", tag, in_ready);
        end
        in_op = 3'(op); in_pred = 1'(pred); in_funct4 = 4'(f4);
        in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = 14'(imm);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        if (legal) begin
            n_cmp++;
            if ({imem_we, imem_addr, imem_wdata} !== {1'b1, m_addr, exp}) begin
                n_bad++;
                $display("FAIL %s emit: got we=%b addr=%h data=%h expected we=1 addr=%h data=%h",
                         tag, imem_we, imem_addr, imem_wdata, m_addr, exp);
            end
            for (int i = 0; i < dly; i++) begin
                tick();
                n_cmp++;
                if ({imem_we, in_ready, imem_addr, imem_wdata} !== {2'b10, m_addr, exp}) begin
                    n_bad++;
                    $display("FAIL %s hold%0d: got we=%b rdy=%b addr=%h data=%h expected we=1 rdy=0 addr=%h data=%h",
                             tag, i, imem_we, in_ready, imem_addr, imem_wdata, m_addr, exp);
                end
            end
            imem_ready = 1'b1;
            tick();
            imem_ready = 1'b0;
            m_addr = m_addr + 1'b1;
            if (m_count != '1) m_count = m_count + 1'b1;
            n_cmp++;
            if ({wr_cnt, imem_we, count} !== {w0 + 1, 1'b0, m_count}) begin
                n_bad++;
                $display("FAIL %s commit: got writes=%0d we=%b count=%0d expected writes=%0d we=0 count=%0d",
                         tag, wr_cnt - w0, imem_we, count, 1, m_count);
            end
            n_cmp++;
            if ({done, in_ready} !== (is_exit ? 2'b10 : 2'b01)) begin
                n_bad++;
                $display("FAIL %s post: got done=%b rdy=%b expected done=%b rdy=%b",
                         tag, done, in_ready, is_exit, !is_exit);
            end
        end else begin
            tick();
            n_cmp++;
            if ({wr_cnt, imem_we, err, in_ready} !== {w0, 3'b011}) begin
                n_bad++;
                $display("FAIL %s illegal: got writes=%0d we=%b err=%b rdy=%b expected writes=0 we=0 err=1 rdy=1",
                         tag, wr_cnt - w0, imem_we, err, in_ready);
            end
        end
    endtask

    task automatic send_rand(input int dly, input bit allow_illegal, input string tag);
        int op, f4;
        op = $urandom_range(0, allow_illegal ? 7 : 3);
        f4 = $urandom_range(0, 15);
        if (!allow_illegal && op == 2) f4 = f4 % 2;
        if (!allow_illegal && op == 3 && ((f4 % 8) == 4 || (f4 % 8) == 5)) f4 = f4 ^ 2;
        if (op == 3 && (f4 % 8) == 7) f4 = f4 ^ 1;
        send(op, $urandom_range(0, 1), f4, $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 16383), dly, tag);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({in_ready, imem_we, imem_addr, imem_wdata, done, count, err} !== '0) begin
            n_bad++;
            $display("FAIL reset: got rdy=%b we=%b addr=%h data=%h done=%b count=%0d err=%b expected all zero",
                     in_ready, imem_we, imem_addr, imem_wdata, done, count, err);
        end
        rst = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({in_ready, imem_we} !== 2'b00) begin
            n_bad++; $display("FAIL idle: got rdy=%b we=%b expected 0 0", in_ready, imem_we);
        end
    endtask

    task automatic test_directed();
        do_start(10'h010);
        send(0, 0, 0, 3, 1, 2, 14'h1234, 0, "rtype_add");
        send(1, 1, 4'h5, 7, 9, 0, 14'h3FFF, 0, "itype_imm");
        send(2, 0, 1, 4, 5, 6, 14'h0ABC, 3, "backpressure");
        send(3, 1, 6, 31, 31, 31, 14'h3FFF, 1, "ctype_sync");
        send(3, 0, 7, 1, 2, 3, 14'h2222, 0, "ctype_exit");
        tick(); tick();
        n_cmp++;
        if ({done, in_ready, imem_we} !== 3'b100) begin
            n_bad++; $display("FAIL done_hold: got done=%b rdy=%b we=%b expected 1 0 0", done, in_ready, imem_we);
        end
        do_start(10'h020);
        n_cmp++;
        if ({done, count, in_ready} !== {1'b0, 10'd0, 1'b1}) begin
            n_bad++; $display("FAIL restart: got done=%b count=%0d rdy=%b expected 0 0 1", done, count, in_ready);
        end
    endtask

    task automatic test_wrap();
        do_start('1);
        send(1, 0, 2, 1, 1, 0, 100, 0, "wrap_first");
        send(1, 0, 2, 2, 2, 0, 200, 0, "wrap_second");
    endtask

    task automatic test_abort();
        int w0;
        do_start(10'h100);
        w0 = wr_cnt;
        in_op = 3'd1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        start = 1'b1; base_addr = 10'h200;
        tick();
        start = 1'b0; m_addr = 10'h200; m_count = '0;
        n_cmp++;
        if ({wr_cnt, imem_we, imem_addr, count, in_ready} !== {w0, 1'b0, 10'h200, 10'd0, 1'b1}) begin
            n_bad++; $display("FAIL abort_emit: got writes=%0d we=%b addr=%h count=%0d rdy=%b expected 0 0 200 0 1",
                              wr_cnt - w0, imem_we, imem_addr, count, in_ready);
        end
        start = 1'b1; base_addr = 10'h200; in_valid = 1'b1;
        tick();
        start = 1'b0; in_valid = 1'b0;
        tick();
        n_cmp++;
        if ({wr_cnt, imem_we, in_ready} !== {w0, 2'b01}) begin
            n_bad++; $display("FAIL start_vs_valid: got writes=%0d we=%b rdy=%b expected 0 0 1",
                              wr_cnt - w0, imem_we, in_ready);
        end
        send(0, 0, 3, 5, 6, 7, 0, 0, "after_abort");
    endtask

    task automatic test_rst_emit();
        int w0;
        w0 = wr_cnt;
        in_op = 3'd0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        imem_ready = 1'b1;
        tick(); tick();
        imem_ready = 1'b0;
        n_cmp++;
        if ({wr_cnt, imem_we, in_ready, count} !== {w0, 2'b00, 10'd0}) begin
            n_bad++; $display("FAIL rst_emit: got writes=%0d we=%b rdy=%b count=%0d expected 0 0 0 0",
                              wr_cnt - w0, imem_we, in_ready, count);
        end
    endtask

    task automatic test_random();
        do_start(10'($urandom_range(0, 1023)));
        for (int i = 0; i < 150; i++) begin
`ifdef INSTR_ENC_CHECK_EN
            send_rand($urandom_range(0, 3), 1'b1, "random");
`else
            send_rand($urandom_range(0, 3), 1'b0, "random");
`endif
        end
    endtask

    task automatic test_saturate();
        do_start(10'h000);
        for (int i = 0; i < 1026; i++) send_rand(0, 1'b0, "saturate");
        n_cmp++;
        if (count !== 10'h3FF) begin
            n_bad++; $display("FAIL saturate: got count=%0d expected 1023", count);
        end
    endtask

`ifdef INSTR_ENC_CHECK_EN
    task automatic test_illegal();
        do_start(10'h050);
        send(5, 0, 0, 1, 1, 1, 1, 0, "bad_op");
        send(2, 0, 7, 1, 1, 1, 1, 0, "bad_mfunct");
        send(1, 0, 0, 1, 1, 1, 1, 0, "after_bad");
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++; $display("FAIL err_sticky: got %b expected 1", err);
        end
        do_start(10'h060);
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++; $display("FAIL err_clear: got %b expected 0", err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_wrap();
        test_abort();
        test_rst_emit();
`ifdef INSTR_ENC_CHECK_EN
        test_illegal();
`endif
        test_random();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
